lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives the word-wide `data_mem` on behalf of the core pipeline.
- Accepts byte-addressed RV32 load/store requests: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Converts byte addresses to word indices and sign/zero-extends load data.
- Since `data_mem` has only a whole-word `we`, sub-word stores are done as read-modify-write sequences.

Parameters:
- MEMORY_SIZE, 2048, number of 32-bit words in `data_mem`.
- ADDR_WIDTH, $clog2(MEMORY_SIZE), width of the `data_mem` word index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.
- mem_addr  out  ADDR_WIDTH  word index to `data_mem`.
- mem_re  out  1  `data_mem` read enable.
- mem_we  out  1  `data_mem` write enable.
- mem_wdata  out  32  `data_mem` write data.
- mem_rdata  in  32  `data_mem` read data; valid the cycle after `mem_re`.

Behaviour:
- Reset (async, `rst_n`=0):
  - State forced to IDLE.
  - `mem_re`, `mem_we`, `resp_valid`, `resp_err` = 0.
  - `mem_addr`, `mem_wdata`, `resp_rdata` = 0.
  - `req_ready` = 1 once `rst_n` is high.
- Accept: on a clk edge with `req_valid` & `req_ready`, latch `we`, `funct3`, `addr`, `wdata`. `req_ready` = 1 only in IDLE.
- Word index: `mem_addr` = `addr[ADDR_WIDTH+1:2]`. Lane = `addr[1:0]`.
- Error check, done at accept:
  - Error if `addr[31:ADDR_WIDTH+2]` != 0.
  - Error if H/HU with `addr[0]`=1.
  - Error if W with `addr[1:0]` != 0.
  - Error if funct3 is 011, 110 or 111.
  - Error if store with funct3 = 100 or 101.
  - An errored request goes straight to RESP with `resp_err`=1 and makes no memory access.
- States: IDLE, RD, CAP, MRG, WR, RESP.
  - Load: IDLE -> RD (`mem_re`=1) -> CAP -> RESP.
    - In CAP, `mem_rdata` is lane-shifted, extended and registered into `resp_rdata`.
    - `resp_valid` rises 3 cycles after the accept edge.
  - SW: IDLE -> WR (`mem_we`=1, `mem_wdata`=`wdata`) -> RESP. `resp_valid` rises 2 cycles after accept.
  - SB/SH: IDLE -> RD (`mem_re`=1) -> MRG -> WR -> RESP. `resp_valid` rises 4 cycles after accept.
    - In MRG, the read word is captured and the target byte/half is replaced with `wdata[7:0]` / `wdata[15:0]`.
    - All other bytes are preserved.
  - RESP: `resp_valid`=1 and `resp_rdata`/`resp_err` held stable until `resp_ready`=1. On that edge go to IDLE.
- Strobes: `mem_re`/`mem_we` are high for exactly one cycle per access and never both high together. `mem_addr` holds the latched index from RD through WR.
- Extension:
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - Lane select: byte = `word[8*lane +: 8]`, half = `word[16*addr[1] +: 16]`.
- A new request presented during non-IDLE states is ignored (`req_ready`=0) and must be held by the core.
- Reset mid-operation aborts at once.
  - A pending RMW never writes; the memory word is unchanged.
  - No `resp_valid` is produced for the aborted request.
- Back-to-back: the next request can be accepted on the same edge RESP exits? No: accept occurs only from IDLE, giving at least one idle cycle between requests.

Test Plan:
1. SW addr 0x10 wdata 0xDEADBEEF -> one-cycle `mem_we`, `mem_addr`=4, `mem_wdata`=0xDEADBEEF, `resp_valid` 2 cycles after accept, `resp_err`=0. Then LW 0x10 -> `resp_rdata`=0xDEADBEEF, 3 cycles after accept.
2. SB addr 0x11 wdata 0x000000A5 -> `mem_re` then `mem_we` with `mem_wdata`=0xDEADA5EF. Then LB 0x11 -> 0xFFFFFFA5, and LBU 0x11 -> 0x000000A5.
3. SH addr 0x12 wdata 0x00001234 -> word becomes 0x1234A5EF. Then LH 0x12 -> 0x00001234. Then LH 0x13 -> `resp_err`=1, `resp_rdata`=0, no `mem_re`/`mem_we`.
4. LW addr 0x2000 (word 2048, out of range) and funct3=011 -> `resp_err`=1 one cycle after accept, no memory strobes.
5. LW with `resp_ready` held low for 3 cycles -> `resp_valid` and `resp_rdata` stable, `req_ready`=0 throughout. Release -> IDLE next edge, `req_ready`=1.
6. SB started, then `rst_n` pulsed low while in MRG -> `mem_we` never asserted, all outputs 0. Subsequent LW of that word returns its pre-store value.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32 load/store initiator for a word-wide data memory.
// Sub-word stores use read-modify-write because the memory only has a whole-word write enable.
module lsu_mem_ctrl #(
    parameter int MEMORY_SIZE = 2048,
    parameter int ADDR_WIDTH  = $clog2(MEMORY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD, CAP, MRG, WR, RESP} state_t;
    state_t state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        acc_err;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;
    logic [31:0] mask;
    logic [31:0] wrep;
    logic [31:0] merged;
    assign req_ready = rst_n && state == IDLE;
    assign acc_err = (req_addr[31:ADDR_WIDTH+2] != '0)
                  || (req_funct3[1:0] == 2'b01 && req_addr[0])
                  || (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
                  || (req_funct3 == 3'b011)
                  || (req_funct3[2:1] == 2'b11)
                  || (req_we && req_funct3[2]);
    assign byte_v   = mem_rdata[8*lane_q +: 8];
    assign half_v   = mem_rdata[16*lane_q[1] +: 16];
    assign load_ext = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & byte_v[7]}}, byte_v}
                    : f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & half_v[15]}}, half_v}
                    : mem_rdata;
    // Replicate the store data across all lanes, then let the lane mask pick the target bytes.
    assign mask   = f3_q[0] ? (32'h0000_FFFF << (16*lane_q[1])) : (32'h0000_00FF << (8*lane_q));
    assign wrep   = f3_q[0] ? {2{wdata_q}} : {4{wdata_q[7:0]}};
    assign merged = (mem_rdata & ~mask) | (wrep & mask);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    we_q       <= req_we;
                    f3_q       <= req_funct3;
                    lane_q     <= req_addr[1:0];
                    wdata_q    <= req_wdata[15:0];
                    mem_addr   <= req_addr[ADDR_WIDTH+1:2];
                    resp_rdata <= '0;
                    resp_err   <= acc_err;
                    if (acc_err) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else if (req_we && req_funct3[1:0] == 2'b10) begin
                        state     <= WR;
                        mem_we    <= 1'b1;
                        mem_wdata <= req_wdata;
                    end else begin
                        state  <= RD;
                        mem_re <= 1'b1;
                    end
                end
                RD:  state <= we_q ? MRG : CAP;
                CAP: begin
                    resp_rdata <= load_ext;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                MRG: begin
                    mem_wdata <= merged;
                    mem_we    <= 1'b1;
                    state     <= WR;
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: randomized check of lsu_mem_ctrl against a byte-addressed reference memory.
module tb_lsu_mem_ctrl;
    localparam int MEM = 2048;
    localparam int AW  = $clog2(MEM);
    logic          clk = 0;
    logic          rst_n = 1;
    logic          req_valid = 0;
    logic          req_ready;
    logic          req_we = 0;
    logic [2:0]    req_funct3 = 0;
    logic [31:0]   req_addr = 0;
    logic [31:0]   req_wdata = 0;
    logic          resp_valid;
    logic          resp_ready = 0;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   mem [0:MEM-1];
    logic [7:0]    ref_b [0:4*MEM-1];
    int            n_chk = 0;
    int            n_pass = 0;
    int            re_tot = 0;
    int            we_tot = 0;
    int            both_tot = 0;
    logic [31:0]   last_addr = 0;
    lsu_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    always #5 clk = ~clk;
    initial begin
        for (int w = 0; w < MEM; w++) mem[w] = $urandom;
        mem_rdata = 0;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end
    always @(negedge clk) begin
        if (mem_re) re_tot <= re_tot + 1;
        if (mem_we) we_tot <= we_tot + 1;
        if (mem_re && mem_we) both_tot <= both_tot + 1;
        if (mem_re || mem_we) last_addr <= 32'(mem_addr);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold);
        int size, exp_lat, lat, re0, we0, b0;
        logic err;
        logic [31:0] exp_rd;
        size = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        err = addr >= 32'(4*MEM) || f3 == 3'd3 || f3 >= 3'd6 || (we && f3 >= 3'd4)
           || (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'd0);
        exp_rd = 0;
        if (!err && !we) begin
            for (int i = 0; i < size; i++) exp_rd |= 32'(ref_b[addr+i]) << (8*i);
            if (f3 < 3'd4 && size < 4 && exp_rd[8*size-1]) exp_rd |= 32'hFFFF_FFFF << (8*size);
        end
        if (!err && we) for (int i = 0; i < size; i++) ref_b[addr+i] = wdata[8*i +: 8];
        exp_lat = err ? 1 : we ? (size == 4 ? 2 : 4) : 3;
        @(negedge clk);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        chk("ready_idle", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 0;
        re0 = re_tot; we0 = we_tot; b0 = both_tot;
        chk("busy", 32'(req_ready), 0);
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", 32'(resp_err), 32'(err));
        chk("rdata", resp_rdata, exp_rd);
        chk("re_cnt", 32'(re_tot - re0), (!err && !(we && size == 4)) ? 1 : 0);
        chk("we_cnt", 32'(we_tot - we0), (!err && we) ? 1 : 0);
        chk("re_we_excl", 32'(both_tot - b0), 0);
        if (!err) chk("mem_addr", last_addr, addr >> 2);
        if (!err && we) chk("mem_word", mem[addr>>2], ref_word(int'(addr >> 2)));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid), 1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk("hold_ready", 32'(req_ready), 0);
        end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        chk("released", 32'(resp_valid), 0);
        chk("ready_back", 32'(req_ready), 1);
    endtask
    initial begin
        logic [31:0] pre;
        int we0;
        #1 rst_n = 0;
        for (int w = 0; w < MEM; w++) for (int i = 0; i < 4; i++) ref_b[4*w+i] = mem[w][8*i +: 8];
        #1;
        chk("rst_re", 32'(mem_re), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_err", 32'(resp_err), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", resp_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        #1 chk("rst_ready", 32'(req_ready), 1);
        run(1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        chk("tp1_word", mem[4], 32'hDEAD_BEEF);
        run(0, 3'b010, 32'h10, 0, 0);
        run(1, 3'b000, 32'h11, 32'h0000_00A5, 0);
        chk("tp2_word", mem[4], 32'hDEAD_A5EF);
        run(0, 3'b000, 32'h11, 0, 0);
        run(0, 3'b100, 32'h11, 0, 0);
        run(1, 3'b001, 32'h12, 32'h0000_1234, 0);
        chk("tp3_word", mem[4], 32'h1234_A5EF);
        run(0, 3'b001, 32'h12, 0, 0);
        run(0, 3'b001, 32'h13, 0, 0);
        run(0, 3'b010, 32'h2000, 0, 0);
        run(0, 3'b011, 32'h10, 0, 0);
        run(1, 3'b100, 32'h10, 0, 0);
        run(0, 3'b010, 32'h10, 0, 3);
        pre = ref_word(8);
        @(negedge clk);
        req_valid = 1; req_we = 1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'h5A;
        @(posedge clk); #1;
        req_valid = 0;
        we0 = we_tot;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("abort_re", 32'(mem_re), 0);
        chk("abort_we", 32'(mem_we), 0);
        chk("abort_valid", 32'(resp_valid), 0);
        chk("abort_addr", 32'(mem_addr), 0);
        chk("abort_wdata", mem_wdata, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_we", 32'(we_tot - we0), 0);
        chk("abort_no_resp", 32'(resp_valid), 0);
        chk("abort_mem", mem[8], pre);
        run(0, 3'b010, 32'h20, 0, 0);
        for (int k = 0; k < 250; k++) begin
            logic [31:0] a;
            a = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) == 0 ? 32'h2000 + $urandom_range(0, 63) : $urandom)
                                          : 32'($urandom_range(0, 127));
            run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 2));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
